// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared state encodings and channel index constants for the dispatch controller.
package demux_dispatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SELECT = 2'b01,
    SEND   = 2'b10
  } state_t;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Upstream handshake plus per-channel dispatch bus of the controller.
interface demux_dispatch_ctrl_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        ch_enable;
  logic [3:0]        ch_ready;
  logic              s0;
  logic              s1;
  logic [3:0]        ch_valid;
  logic [DATA_W-1:0] ch_data;
  logic              retry;
  logic [CNT_W-1:0]  tx_count;

  // Environment side: source and sinks
  modport master (
    output in_valid, in_data, ch_enable, ch_ready,
    input  in_ready, s0, s1, ch_valid, ch_data, retry, tx_count
  );

  // Controller side
  modport slave (
    input  in_valid, in_data, ch_enable, ch_ready,
    output in_ready, s0, s1, ch_valid, ch_data, retry, tx_count
  );
endinterface

// File: rtl/demux_dispatch_ctrl_demux.sv
// Gate-level 1:4 demux: routes input a to one of four outputs selected by {s1,s0}.
module one_bit_1_4_demux (
  input  logic a,
  input  logic s0,
  input  logic s1,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4
);
  logic w_ns0;
  logic w_ns1;

  not u_not_s0 (w_ns0, s0);
  not u_not_s1 (w_ns1, s1);

  and u_and_out1 (out1, a, w_ns1, w_ns0);
  and u_and_out2 (out2, a, w_ns1, s0);
  and u_and_out3 (out3, a, s1, w_ns0);
  and u_and_out4 (out4, a, s1, s0);
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Round-robin dispatch controller: buffers one item, picks an enabled channel,
// strobes it through the 1:4 demux and re-arbitrates on stall timeout.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  demux_dispatch_ctrl_if.slave bus
);

  localparam int unsigned      WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  state_t              r_state, w_state;
  logic [1:0]          r_ptr, w_ptr;
  logic [1:0]          r_sel, w_sel;
  logic [DATA_W-1:0]   r_buf, w_buf;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt;
  logic [CNT_W-1:0]    r_tx_count, w_tx_count;
  logic                r_retry, w_retry;
  logic [2:0]          w_scan;
  logic                w_strobe;
  logic [3:0]          w_ch_valid;

  // First enabled channel at or after start (wrapping); bit 2 flags a hit.
  function automatic logic [2:0] f_rr_scan(input logic [3:0] en, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (en[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= CH0;
      r_sel      <= CH0;
      r_buf      <= '0;
      r_wait_cnt <= '0;
      r_tx_count <= '0;
      r_retry    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_sel      <= w_sel;
      r_buf      <= w_buf;
      r_wait_cnt <= w_wait_cnt;
      r_tx_count <= w_tx_count;
      r_retry    <= w_retry;
    end
  end

  // Next-state, arbitration and stall-timeout logic
  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_sel      = r_sel;
    w_buf      = r_buf;
    w_wait_cnt = r_wait_cnt;
    w_tx_count = r_tx_count;
    w_retry    = 1'b0;
    w_scan     = f_rr_scan(bus.ch_enable, r_ptr);
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_buf   = bus.in_data;
          w_state = SELECT;
        end
      end
      SELECT: begin
        if (w_scan[2]) begin
          w_sel      = w_scan[1:0];
          w_wait_cnt = '0;
          w_state    = SEND;
        end
      end
      SEND: begin
        if (bus.ch_ready[r_sel]) begin
          w_ptr      = r_sel + 2'd1;
          w_tx_count = r_tx_count + CNT_W'(1);
          w_state    = IDLE;
        end else if (!bus.ch_enable[r_sel]) begin
          w_ptr   = r_sel + 2'd1;
          w_state = SELECT;
        end else if (TIMEOUT_EN && (r_wait_cnt == WAIT_LAST)) begin
          w_retry = 1'b1;
          w_ptr   = r_sel + 2'd1;
          w_state = SELECT;
        end else begin
          w_wait_cnt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign w_strobe = (r_state == SEND);

  // One-hot channel valid from the gate-level demux
  one_bit_1_4_demux u_demux (
    .a    (w_strobe),
    .s0   (r_sel[0]),
    .s1   (r_sel[1]),
    .out1 (w_ch_valid[0]),
    .out2 (w_ch_valid[1]),
    .out3 (w_ch_valid[2]),
    .out4 (w_ch_valid[3])
  );

  assign bus.in_ready = (r_state == IDLE);
  assign bus.s0       = r_sel[0];
  assign bus.s1       = r_sel[1];
  assign bus.ch_valid = w_ch_valid;
  assign bus.ch_data  = r_buf;
  assign bus.retry    = r_retry;
  assign bus.tx_count = r_tx_count;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed self-checking bench for demux_dispatch_ctrl (DATA_W=1, TIMEOUT=8, CNT_W=8).
module tb_demux_dispatch_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_tx;
  int   exp_ptr;

  demux_dispatch_ctrl_if #(.DATA_W(1), .CNT_W(8)) bus ();

  demux_dispatch_ctrl #(.DATA_W(1), .TIMEOUT(8), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_tx  = 8'd0;
    exp_ptr = 0;
  endtask

  // One item through IDLE -> SELECT -> SEND -> IDLE; ch_ready[ch] must be high.
  task automatic deliver(input logic d, input int ch);
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("select_ch_valid", 32'(bus.ch_valid), 32'd0);
    chk("select_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("send_ch_valid", 32'(bus.ch_valid), 32'(1) << ch);
    chk("send_sel", 32'({bus.s1, bus.s0}), 32'(ch));
    chk("send_data", 32'(bus.ch_data), 32'(d));
    exp_tx++;
    exp_ptr = (ch + 1) % 4;
    @(negedge clk);
    chk("done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("done_tx_count", 32'(bus.tx_count), 32'(exp_tx));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    bus.ch_enable = 4'b1111;
    bus.ch_ready  = 4'b1111;
    do_reset();

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ch_valid", 32'(bus.ch_valid), 32'd0);
    chk("rst_ch_data", 32'(bus.ch_data), 32'd0);
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
    chk("rst_retry", 32'(bus.retry), 32'd0);
    chk("rst_sel", 32'({bus.s1, bus.s0}), 32'd0);

    // Round robin over all channels
    deliver(1'b1, 0);
    deliver(1'b0, 1);
    deliver(1'b1, 2);
    deliver(1'b1, 3);
    chk("rr_tx_count4", 32'(bus.tx_count), 32'd4);
    deliver(1'b0, 0);

    // Enable mask 1010 from ptr 0
    do_reset();
    bus.ch_enable = 4'b1010;
    deliver(1'b1, 1);
    deliver(1'b0, 3);

    // Stall timeout on ch2, then re-arbitrated to ch3 with same payload
    bus.ch_enable = 4'b1100;
    bus.ch_ready  = 4'b1011;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_ch_valid", 32'(bus.ch_valid), 32'h4);
      chk("stall_retry", 32'(bus.retry), 32'd0);
    end
    @(negedge clk);
    chk("timeout_retry", 32'(bus.retry), 32'd1);
    chk("timeout_ch_valid", 32'(bus.ch_valid), 32'd0);
    chk("timeout_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("retry_pulse_end", 32'(bus.retry), 32'd0);
    chk("resend_ch_valid", 32'(bus.ch_valid), 32'h8);
    chk("resend_data", 32'(bus.ch_data), 32'd1);
    exp_tx++;
    @(negedge clk);
    chk("resend_tx_count", 32'(bus.tx_count), 32'(exp_tx));
    chk("resend_in_ready", 32'(bus.in_ready), 32'd1);

    // No channel enabled: item held in SELECT
    bus.ch_ready  = 4'b1111;
    bus.ch_enable = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_ch_valid", 32'(bus.ch_valid), 32'd0);
    end
    bus.ch_enable = 4'b0100;
    @(negedge clk);
    chk("hold_release_ch_valid", 32'(bus.ch_valid), 32'h4);
    chk("hold_release_data", 32'(bus.ch_data), 32'd1);
    exp_tx++;
    @(negedge clk);
    chk("hold_tx_count", 32'(bus.tx_count), 32'(exp_tx));

    // Reset during SEND to ch1
    bus.ch_enable = 4'b0010;
    bus.ch_ready  = 4'b1101;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ch_valid", 32'(bus.ch_valid), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_tx  = 8'd0;
    exp_ptr = 0;
    chk("midrst_ch_valid", 32'(bus.ch_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_tx_count", 32'(bus.tx_count), 32'd0);
    chk("midrst_sel", 32'({bus.s1, bus.s0}), 32'd0);
    bus.ch_enable = 4'b1111;
    bus.ch_ready  = 4'b1111;
    deliver(1'b0, 0);

    // Counter wrap at 255 -> 0
    for (int i = 0; i < 254; i++) deliver(1'(i), exp_ptr);
    chk("wrap_tx_255", 32'(bus.tx_count), 32'd255);
    deliver(1'b1, exp_ptr);
    chk("wrap_tx_0", 32'(bus.tx_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
